// File: rtl/cache_parameters.sv
// Bus widths shared by the cache and everything hanging off its Wishbone port.
package cache_parameters;
    localparam int WORD_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;
endpackage

// File: rtl/memory_mapping.sv
// Word-address map of the RAM region serviced behind the cache.
package memory_mapping;
    localparam logic [cache_parameters::ADDR_WIDTH-1:0] RAM_BASE = 32'h0000_1000;
    localparam int RAM_DEPTH = 1024;
endpackage

// File: rtl/ram_sp_sync.sv
// Single-port synchronous RAM; the read port is a register loaded only when re_i is high.
module ram_sp_sync #(
    parameter int DEPTH  = 1024,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // The array is deliberately left without reset so its contents survive RST_I.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/wshbn_slave_ram.sv
// Wishbone classic slave fronting a word-addressed RAM, with a fixed number of
// wait states before each single-cycle ACK_O.
module wshbn_slave_ram
    import cache_parameters::*;
#(
    parameter int                    WAIT_STATES = 2,
    parameter int                    RAM_DEPTH   = memory_mapping::RAM_DEPTH,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = memory_mapping::RAM_BASE
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic [ADDR_WIDTH-1:0] ADR_I,
    input  logic [WORD_WIDTH-1:0] DAT_I,
    output logic [WORD_WIDTH-1:0] DAT_O,
    input  logic                  WE_I,
    input  logic                  STB_I,
    input  logic                  CYC_I,
    output logic                  ACK_O
);

    localparam int IDX_W = $clog2(RAM_DEPTH);
    localparam int OFF_W = ADDR_WIDTH + 1;
    localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zero_q, zero_d;

    logic             req;
    logic [OFF_W-1:0] offset;
    logic             in_range;
    logic [IDX_W-1:0] ram_idx;
    logic             ram_we;
    logic             ram_re;
    logic [WORD_WIDTH-1:0] ram_rdata;

    assign req = STB_I & CYC_I;

    // One extra bit so an address below BASE_ADDR shows up as a borrow.
    assign offset   = {1'b0, ADR_I} - {1'b0, BASE_ADDR};
    assign in_range = !offset[OFF_W-1] && (offset < OFF_W'(RAM_DEPTH));
    assign ram_idx  = offset[IDX_W-1:0];

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_d = ST_ACK;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Out-of-range reads are remembered at capture and forced to zero on DAT_O.
        zero_d = (state_d == ST_ACK) ? !in_range : zero_q;
    end

    always_comb begin
        ACK_O  = (state_q == ST_ACK);
        ram_re = (state_d == ST_ACK);
        ram_we = (state_q == ST_ACK) && WE_I && in_range;
    end

    ram_sp_sync #(
        .DEPTH  (RAM_DEPTH),
        .WIDTH  (WORD_WIDTH),
        .ADDR_W (IDX_W)
    ) u_ram (
        .clk_i   (CLK_I),
        .rst_i   (RST_I),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_idx),
        .wdata_i (DAT_I),
        .rdata_o (ram_rdata)
    );

    assign DAT_O = zero_q ? '0 : ram_rdata;

endmodule

// File: tb/tb_wshbn_slave_ram.sv
// Bench for wshbn_slave_ram: one instance with two wait states, one with none.
module tb_wshbn_slave_ram;
    import cache_parameters::*;

    localparam logic [ADDR_WIDTH-1:0] BASE = memory_mapping::RAM_BASE;
    localparam int DEPTH = memory_mapping::RAM_DEPTH;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    logic                  rst2, rst0;
    logic [ADDR_WIDTH-1:0] adr2, adr0;
    logic [WORD_WIDTH-1:0] dat_i2, dat_i0, dat_o2, dat_o0;
    logic                  we2, we0, stb2, stb0, cyc2, cyc0, ack2, ack0;

    wshbn_slave_ram #(.WAIT_STATES(2)) dut2 (
        .CLK_I(clk), .RST_I(rst2), .ADR_I(adr2), .DAT_I(dat_i2), .DAT_O(dat_o2),
        .WE_I(we2), .STB_I(stb2), .CYC_I(cyc2), .ACK_O(ack2)
    );

    wshbn_slave_ram #(.WAIT_STATES(0)) dut0 (
        .CLK_I(clk), .RST_I(rst0), .ADR_I(adr0), .DAT_I(dat_i0), .DAT_O(dat_o0),
        .WE_I(we0), .STB_I(stb0), .CYC_I(cyc0), .ACK_O(ack0)
    );

    int tests = 0;
    int fails = 0;

    // ---------------- scoreboard ----------------
    logic [WORD_WIDTH-1:0] exp_q2[$], exp_q0[$];
    int                    exp_cyc_q2[$], exp_cyc_q0[$];
    bit                    exp_rd_q2[$], exp_rd_q0[$];

    logic [WORD_WIDTH-1:0] m_e2, m_e0;
    int                    m_c2, m_c0;
    bit                    m_r2, m_r0;

    always @(negedge clk) begin
        if (ack2) begin
            tests++;
            if (exp_q2.size() == 0) begin
                fails++;
                $display("FAIL ack2_unexpected: ACK_O high in cycle %0d, required none", cyc_n);
            end else begin
                m_e2 = exp_q2.pop_front();
                m_c2 = exp_cyc_q2.pop_front();
                m_r2 = exp_rd_q2.pop_front();
                if (m_c2 != cyc_n) begin
                    fails++;
                    $display("FAIL ack2_latency: ACK_O in cycle %0d, required cycle %0d", cyc_n, m_c2);
                end
                if (m_r2) begin
                    tests++;
                    if (dat_o2 !== m_e2) begin
                        fails++;
                        $display("FAIL ack2_data: DAT_O=%h, required %h", dat_o2, m_e2);
                    end
                end
            end
        end
        if (ack0) begin
            tests++;
            if (exp_q0.size() == 0) begin
                fails++;
                $display("FAIL ack0_unexpected: ACK_O high in cycle %0d, required none", cyc_n);
            end else begin
                m_e0 = exp_q0.pop_front();
                m_c0 = exp_cyc_q0.pop_front();
                m_r0 = exp_rd_q0.pop_front();
                if (m_c0 != cyc_n) begin
                    fails++;
                    $display("FAIL ack0_latency: ACK_O in cycle %0d, required cycle %0d", cyc_n, m_c0);
                end
                if (m_r0) begin
                    tests++;
                    if (dat_o0 !== m_e0) begin
                        fails++;
                        $display("FAIL ack0_data: DAT_O=%h, required %h", dat_o0, m_e0);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // z selects the zero-wait instance; the beat returns on the negedge of its ACK cycle.
    task automatic beat(input bit z, input logic [ADDR_WIDTH-1:0] adr, input bit we,
                        input logic [WORD_WIDTH-1:0] data, input logic [WORD_WIDTH-1:0] exp);
        int  start;
        bit  got;
        @(negedge clk);
        start = cyc_n;
        if (z) begin
            adr0 = adr; we0 = we; dat_i0 = data; stb0 = 1'b1; cyc0 = 1'b1;
            exp_q0.push_back(exp); exp_cyc_q0.push_back(start + 1); exp_rd_q0.push_back(!we);
        end else begin
            adr2 = adr; we2 = we; dat_i2 = data; stb2 = 1'b1; cyc2 = 1'b1;
            exp_q2.push_back(exp); exp_cyc_q2.push_back(start + 3); exp_rd_q2.push_back(!we);
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = z ? ack0 : ack2;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL beat_timeout: no ACK_O for adr %h within 20 cycles, required one", adr);
        end
    endtask

    task automatic idle(input bit z);
        @(negedge clk);
        if (z) begin stb0 = 1'b0; cyc0 = 1'b0; end
        else   begin stb2 = 1'b0; cyc2 = 1'b0; end
    endtask

    task automatic check(input string name, input logic [WORD_WIDTH-1:0] act,
                         input logic [WORD_WIDTH-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst2 = 1'b1; rst0 = 1'b1;
        adr2 = '0; dat_i2 = '0; we2 = 1'b0; stb2 = 1'b0; cyc2 = 1'b0;
        adr0 = '0; dat_i0 = '0; we0 = 1'b0; stb0 = 1'b0; cyc0 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ack2", {31'b0, ack2}, 32'h0);
        check("reset_dat2", dat_o2, 32'h0);
        check("reset_ack0", {31'b0, ack0}, 32'h0);
        check("reset_dat0", dat_o0, 32'h0);
        rst2 = 1'b0; rst0 = 1'b0;

        // single write then read
        beat(0, BASE + 5, 1, 32'hDEADBEEF, 32'h0);
        idle(0);
        beat(0, BASE + 5, 0, 32'h0, 32'hDEADBEEF);
        idle(0);

        // cache-style block burst: 4 writes then 4 reads, STB held across beats
        for (int i = 0; i < 4; i++) beat(0, BASE + 8 + i, 1, 32'(i + 1), 32'h0);
        idle(0);
        for (int i = 0; i < 4; i++) beat(0, BASE + 8 + i, 0, 32'h0, 32'(i + 1));
        idle(0);

        // zero wait states, back-to-back
        beat(1, BASE + 0, 1, 32'h12345678, 32'h0);
        beat(1, BASE + 1, 1, 32'h00000011, 32'h0);
        idle(1);
        beat(1, BASE + 0, 0, 32'h0, 32'h12345678);
        beat(1, BASE + 1, 0, 32'h0, 32'h00000011);
        idle(1);

        // abort: STB dropped in cycle 1 of a write
        beat(0, BASE + 3, 1, 32'hA5A5A5A5, 32'h0);
        idle(0);
        @(negedge clk);
        adr2 = BASE + 3; we2 = 1'b1; dat_i2 = 32'h0BAD0BAD; stb2 = 1'b1; cyc2 = 1'b1;
        @(negedge clk);
        stb2 = 1'b0; cyc2 = 1'b0;
        repeat (6) @(negedge clk);
        beat(0, BASE + 3, 0, 32'h0, 32'hA5A5A5A5);
        idle(0);

        // out of range, above and below the window
        beat(0, BASE + 0, 1, 32'h0000CAFE, 32'h0);
        beat(0, BASE + DEPTH, 1, 32'hFFFF0000, 32'h0);
        beat(0, BASE + DEPTH, 0, 32'h0, 32'h0);
        beat(0, BASE + 0, 0, 32'h0, 32'h0000CAFE);
        beat(0, BASE - 1, 0, 32'h0, 32'h0);
        beat(0, BASE + DEPTH - 1, 1, 32'h0000BEEF, 32'h0);
        beat(0, BASE + DEPTH - 1, 0, 32'h0, 32'h0000BEEF);
        idle(0);

        // reset mid-beat
        beat(0, BASE + 7, 1, 32'h77777777, 32'h0);
        beat(0, BASE + 7, 0, 32'h0, 32'h77777777);
        idle(0);
        repeat (2) @(negedge clk);
        check("dat_hold", dat_o2, 32'h77777777);
        @(negedge clk);
        adr2 = BASE + 7; we2 = 1'b1; dat_i2 = 32'hCCCCCCCC; stb2 = 1'b1; cyc2 = 1'b1;
        @(negedge clk);
        rst2 = 1'b1;
        #1;
        check("midreset_ack", {31'b0, ack2}, 32'h0);
        check("midreset_dat", dat_o2, 32'h0);
        @(negedge clk);
        rst2 = 1'b0; stb2 = 1'b0; cyc2 = 1'b0;
        beat(0, BASE + 7, 0, 32'h0, 32'h77777777);
        idle(0);

        repeat (6) @(negedge clk);
        tests++;
        if (exp_q2.size() != 0 || exp_q0.size() != 0) begin
            fails++;
            $display("FAIL missing_ack: %0d/%0d expected ACKs outstanding, required 0/0",
                     exp_q2.size(), exp_q0.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wshbn_slave_ram.md
Name: wshbn_slave_ram

Overview:
- Wishbone classic slave holding a word-addressed RAM.
- Sits directly downstream of the cache's Wishbone master and services its per-word block refills (read) and write-backs (write).
- Each beat is acknowledged with a single-cycle ACK_O after a programmable number of wait states.
- The master steps ADR_I by one word per ACK, so the block must tolerate back-to-back beats with a changing address.

Parameters:
- WAIT_STATES, 2, idle cycles inserted between beat acceptance and ACK_O (0 allowed).
- RAM_DEPTH, 1024, number of WORD_WIDTH words stored (power of two).
- BASE_ADDR, RAM_BASE (memory_mapping), first word address decoded by this slave.

Ports:
- CLK_I  in  1  system clock, rising edge.
- RST_I  in  1  reset, asynchronous, active-high.
- ADR_I  in  ADDR_WIDTH  word address from master.
- DAT_I  in  WORD_WIDTH  write data.
- DAT_O  out  WORD_WIDTH  read data, valid while ACK_O=1.
- WE_I  in  1  1=write, 0=read.
- STB_I  in  1  strobe.
- CYC_I  in  1  bus cycle active.
- ACK_O  out  1  beat acknowledge, one-cycle pulse.

Behaviour:
- Reset: state=IDLE, wait counter=0, ACK_O=0, DAT_O=0. RAM contents are not cleared. Reset mid-beat abandons the beat: no write occurs and no ACK is produced.
- Beat request: req = STB_I & CYC_I.
- States: IDLE, WAIT, ACK.
- IDLE:
  - req=1 and WAIT_STATES>0 -> WAIT, counter loaded with WAIT_STATES-1.
  - req=1 and WAIT_STATES=0 -> ACK.
  - Otherwise stay in IDLE.
- WAIT:
  - req=0 -> IDLE (abort, no side effect).
  - counter=0 -> ACK.
  - Otherwise decrement counter.
- Read capture: on the edge entering ACK, DAT_O is loaded with RAM[ADR_I-BASE_ADDR] when the address is in range, else 0.
- ACK: ACK_O=1 for exactly this one cycle.
  - If WE_I=1 and address in range, RAM is written with DAT_I on the edge leaving ACK.
  - Next state is always IDLE, even if req is still high.
- Latency: if STB_I first rises in cycle 0, ACK_O is high in cycle WAIT_STATES+1. Beat period is WAIT_STATES+2 cycles. The IDLE cycle after ACK samples the next address; it is cycle 0 of the next beat.
- ADR_I, WE_I and DAT_I are sampled at the capture/write edges only. Their values during WAIT are don't-care.
- Address range: in range iff BASE_ADDR <= ADR_I < BASE_ADDR+RAM_DEPTH. Index is (ADR_I-BASE_ADDR) truncated to $clog2(RAM_DEPTH) bits.
- Out-of-range beats are still acknowledged so the master cannot hang. Read returns 0; write is dropped.
- DAT_O holds its value outside ACK. Users must qualify it with ACK_O.
- req dropping during ACK has no effect: the ACK completes and the write (if WE_I=1) still happens, because the master has already committed.

Decomposition:
- memory_mapping package: RAM_BASE and RAM_DEPTH constants.
- cache_parameters package (existing): WORD_WIDTH and ADDR_WIDTH, reused.
- State enum is local to the module.
- One sub-module: ram_sp_sync.
  - Single-port array of RAM_DEPTH x WORD_WIDTH.
  - Inputs: we, addr, wdata, re. Output: rdata, registered on re.
  - No reset on the array.
  - Instantiated once. The FSM drives re on ACK entry and we on ACK exit.

Test Plan:
- Single write then read: WAIT_STATES=2, write ADR=BASE+5 DAT=32'hDEADBEEF.
  - ACK_O in cycle 3, one cycle wide.
  - Read of BASE+5 returns DEADBEEF with ACK in cycle 3.
- Block burst as the cache master drives it: 4 writes BASE+8..11 (data 1,2,3,4), then 4 reads.
  - Exactly 4 ACKs each way, 4 cycles apart.
  - Read data 1,2,3,4 in order.
  - No double-write on the IDLE gap cycle.
- Zero wait states: WAIT_STATES=0, read BASE+0 preloaded with 32'h12345678.
  - ACK_O in cycle 1 with DAT_O=12345678.
  - Beat period 2 cycles.
- Abort: STB_I dropped in cycle 1 of a write (WAIT_STATES=2) to BASE+3 with old value 32'hA5A5A5A5.
  - No ACK_O.
  - Subsequent read returns A5A5A5A5.
- Out of range: write to BASE+RAM_DEPTH, then read the same address.
  - Both are ACKed.
  - Read data is 0.
  - RAM[0] is unchanged.
- Reset mid-beat: RST_I pulsed in the WAIT cycle of a write.
  - ACK_O=0 and DAT_O=0 immediately (asynchronous).
  - Target word is unchanged.
  - The next beat after reset completes normally.
